// File: rtl/fighter_anim_ctrl_if.sv
// Button/hit inputs and sprite/collision outputs of one player's animation sequencer.
// The master side (game logic or bench) drives the inputs; the slave side is the sequencer.
interface fighter_anim_ctrl_if;
  logic       frame_tick;
  logic       btn_punch;
  logic       btn_kick;
  logic       btn_left;
  logic       btn_right;
  logic       hit_taken;
  logic [2:0] sprite_sel;
  logic [3:0] anim_frame;
  logic       hitbox_active;
  logic [1:0] attack_type;
  logic       busy;

  modport master (
    output frame_tick, btn_punch, btn_kick, btn_left, btn_right, hit_taken,
    input  sprite_sel, anim_frame, hitbox_active, attack_type, busy
  );

  modport slave (
    input  frame_tick, btn_punch, btn_kick, btn_left, btn_right, hit_taken,
    output sprite_sel, anim_frame, hitbox_active, attack_type, busy
  );
endinterface

// File: rtl/fighter_anim_ctrl.sv
// Per-player move sequencer: steps idle/walk/punch/kick/recovery/hit-stun once per frame
// and drives registered sprite, walk-cycle, hitbox and busy outputs.
module fighter_anim_ctrl #(
  parameter int PUNCH_ACT   = 6,
  parameter int KICK_WIND   = 4,
  parameter int KICK_ACT    = 6,
  parameter int RECOVER     = 8,
  parameter int STUN        = 12,
  parameter int WALK_DIV    = 4,
  parameter int WALK_FRAMES = 4
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  fighter_anim_ctrl_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_DUR = max2(max2(max2(PUNCH_ACT, KICK_WIND), max2(KICK_ACT, RECOVER)), STUN);
  localparam int CNT_W   = $clog2(MAX_DUR) + 1;
  localparam int DIV_W   = $clog2(WALK_DIV) + 1;

  localparam logic [CNT_W-1:0] LD_PUNCH = CNT_W'(PUNCH_ACT - 1);
  localparam logic [CNT_W-1:0] LD_KWIND = CNT_W'(KICK_WIND - 1);
  localparam logic [CNT_W-1:0] LD_KACT  = CNT_W'(KICK_ACT - 1);
  localparam logic [CNT_W-1:0] LD_REC   = CNT_W'(RECOVER - 1);
  localparam logic [CNT_W-1:0] LD_STUN  = CNT_W'(STUN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(WALK_DIV - 1);
  localparam logic [3:0]       ANIM_LAST = 4'(WALK_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WALK, S_PUNCH, S_KICK_W, S_KICK_A, S_RECOV, S_HURT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       r_anim, w_anim_nxt;
  logic             r_hit_latch;
  logic             w_hit;
  logic [2:0]       r_sprite, w_sprite;
  logic             r_hitbox, w_hitbox;
  logic [1:0]       r_type, w_type;
  logic             r_busy, w_busy;

  // Next-state: nothing moves except on the frame tick
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_anim_nxt  = r_anim;
    w_hit       = r_hit_latch | bus.hit_taken;
    if (bus.frame_tick) begin
      if (w_hit) begin
        w_state_nxt = S_HURT;
        w_cnt_nxt   = LD_STUN;
      end else begin
        unique case (r_state)
          S_IDLE, S_WALK: begin
            w_cnt_nxt = '0;
            if (bus.btn_kick) begin
              w_state_nxt = S_KICK_W;
              w_cnt_nxt   = LD_KWIND;
            end else if (bus.btn_punch) begin
              w_state_nxt = S_PUNCH;
              w_cnt_nxt   = LD_PUNCH;
            end else if (bus.btn_left ^ bus.btn_right) begin
              w_state_nxt = S_WALK;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          S_PUNCH, S_KICK_A: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_RECOV;
              w_cnt_nxt   = LD_REC;
            end else w_cnt_nxt = r_cnt - CNT_W'(1);
          end
          S_KICK_W: begin
            if (r_cnt == '0) begin
              w_state_nxt = S_KICK_A;
              w_cnt_nxt   = LD_KACT;
            end else w_cnt_nxt = r_cnt - CNT_W'(1);
          end
          S_RECOV, S_HURT: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
      // Walk cycle only advances while remaining in WALK; entering or leaving restarts it
      if (w_state_nxt == S_WALK && r_state == S_WALK) begin
        if (r_div == DIV_LAST) begin
          w_div_nxt  = '0;
          w_anim_nxt = (r_anim == ANIM_LAST) ? 4'd0 : r_anim + 4'd1;
        end else begin
          w_div_nxt  = r_div + DIV_W'(1);
        end
      end else begin
        w_div_nxt  = '0;
        w_anim_nxt = 4'd0;
      end
    end
  end

  always_comb begin
    w_sprite = 3'd0;
    w_hitbox = 1'b0;
    w_type   = 2'd0;
    w_busy   = 1'b1;
    unique case (w_state_nxt)
      S_IDLE:   w_busy = 1'b0;
      S_WALK: begin
        w_sprite = 3'd1;
        w_busy   = 1'b0;
      end
      S_PUNCH: begin
        w_sprite = 3'd2;
        w_hitbox = 1'b1;
        w_type   = 2'd1;
      end
      S_KICK_W: w_sprite = 3'd3;
      S_KICK_A: begin
        w_sprite = 3'd3;
        w_hitbox = 1'b1;
        w_type   = 2'd2;
      end
      S_RECOV:  w_sprite = 3'd0;
      S_HURT:   w_sprite = 3'd4;
      default:  w_busy   = 1'b0;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_anim      <= 4'd0;
      r_hit_latch <= 1'b0;
      r_sprite    <= 3'd0;
      r_hitbox    <= 1'b0;
      r_type      <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_anim      <= w_anim_nxt;
      r_hit_latch <= bus.frame_tick ? 1'b0 : w_hit;
      r_sprite    <= w_sprite;
      r_hitbox    <= w_hitbox;
      r_type      <= w_type;
      r_busy      <= w_busy;
    end
  end

  assign bus.sprite_sel    = r_sprite;
  assign bus.anim_frame    = r_anim;
  assign bus.hitbox_active = r_hitbox;
  assign bus.attack_type   = r_type;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Scoreboard bench for fighter_anim_ctrl: a per-frame output script model predicts each
// registered update; a monitor compares every cycle against the latest prediction.
module tb_fighter_anim_ctrl;
  localparam int PA = 6, KW = 4, KA = 6, RC = 8, ST = 12, WD = 4, WF = 4;

  typedef struct packed {
    logic [2:0] spr;
    logic [3:0] anim;
    logic       hb;
    logic [1:0] typ;
    logic       busy;
  } exp_t;

  localparam exp_t E_IDLE  = '{3'd0, 4'd0, 1'b0, 2'd0, 1'b0};
  localparam exp_t E_PUNCH = '{3'd2, 4'd0, 1'b1, 2'd1, 1'b1};
  localparam exp_t E_KWIND = '{3'd3, 4'd0, 1'b0, 2'd0, 1'b1};
  localparam exp_t E_KACT  = '{3'd3, 4'd0, 1'b1, 2'd2, 1'b1};
  localparam exp_t E_RECOV = '{3'd0, 4'd0, 1'b0, 2'd0, 1'b1};
  localparam exp_t E_HURT  = '{3'd4, 4'd0, 1'b0, 2'd0, 1'b1};

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  fighter_anim_ctrl_if bus();

  fighter_anim_ctrl #(
    .PUNCH_ACT(PA), .KICK_WIND(KW), .KICK_ACT(KA), .RECOVER(RC),
    .STUN(ST), .WALK_DIV(WD), .WALK_FRAMES(WF)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  exp_t sb_q[$];
  exp_t script[$];
  bit   hit_pend;
  bit   walking;
  int   walk_n;
  int   checks = 0;
  int   errors = 0;

  function automatic void push_n(input exp_t e, input int n);
    for (int i = 0; i < n; i++) script.push_back(e);
  endfunction

  // Each move expands into its full per-frame output sequence, ending with one forced idle frame
  function automatic exp_t model_tick(input bit [3:0] b, input bit hit);
    exp_t w;
    if (hit) begin
      script.delete();
      push_n(E_HURT, ST);
      push_n(E_IDLE, 1);
      walking = 0;
    end else if (script.size() == 0) begin
      if (b[3]) begin
        push_n(E_KWIND, KW); push_n(E_KACT, KA); push_n(E_RECOV, RC); push_n(E_IDLE, 1);
        walking = 0;
      end else if (b[2]) begin
        push_n(E_PUNCH, PA); push_n(E_RECOV, RC); push_n(E_IDLE, 1);
        walking = 0;
      end else if (b[1] ^ b[0]) begin
        walk_n  = walking ? walk_n + 1 : 0;
        walking = 1;
        w = E_IDLE;
        w.spr  = 3'd1;
        w.anim = 4'((walk_n / WD) % WF);
        script.push_back(w);
      end else begin
        walking = 0;
        script.push_back(E_IDLE);
      end
    end
    return script.pop_front();
  endfunction

  task automatic cyc(input bit tick, input bit [3:0] b, input bit hit);
    @(negedge vga_clk);
    reset_n        = 1'b1;
    bus.frame_tick = tick;
    {bus.btn_kick, bus.btn_punch, bus.btn_left, bus.btn_right} = b;
    bus.hit_taken  = hit;
    if (tick) begin
      sb_q.push_back(model_tick(b, hit_pend | hit));
      hit_pend = 0;
    end else begin
      hit_pend = hit_pend | hit;
    end
  endtask

  task automatic ticks(input int n, input bit [3:0] b);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 4'b0000, 1'b0);
      cyc(1'b1, b, 1'b0);
    end
  endtask

  task automatic rst_pulse();
    @(negedge vga_clk);
    reset_n = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.btn_kick, bus.btn_punch, bus.btn_left, bus.btn_right} = 4'b0000;
    bus.hit_taken = 1'b0;
    script.delete();
    hit_pend = 0;
    walking  = 0;
    sb_q.push_back(E_IDLE);
  endtask

  // Monitor: an edge with reset or frame_tick consumes one prediction; others must hold outputs
  bit   ev;
  bit   armed;
  exp_t cur;
  exp_t act;
  always @(posedge vga_clk) ev = !reset_n || bus.frame_tick;

  always @(negedge vga_clk) begin
    if (ev) begin
      armed = 1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow t=%0t: DUT update with no prediction queued", $time);
      end else begin
        cur = sb_q.pop_front();
      end
    end
    if (armed) begin
      checks++;
      act = {bus.sprite_sel, bus.anim_frame, bus.hitbox_active, bus.attack_type, bus.busy};
      if (act !== cur) begin
        errors++;
        $display("FAIL outputs t=%0t got spr=%0d anim=%0d hb=%0b typ=%0d busy=%0b, required spr=%0d anim=%0d hb=%0b typ=%0d busy=%0b",
                 $time, act.spr, act.anim, act.hb, act.typ, act.busy,
                 cur.spr, cur.anim, cur.hb, cur.typ, cur.busy);
      end
    end
  end

  initial begin
    bit [3:0] cur_b;
    bus.frame_tick = 1'b0;
    bus.btn_kick = 1'b0; bus.btn_punch = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.hit_taken = 1'b0;
    sb_q.push_back(E_IDLE);
    rst_pulse();

    ticks(5, 4'b0000);
    // Kick tapped for one frame, full sequence plus settle
    ticks(1, 4'b1000);
    ticks(20, 4'b0000);
    // Walk right 20 frames, then release
    ticks(20, 4'b0001);
    ticks(2, 4'b0000);
    // Punch interrupted by mid-frame hit on 3rd active frame, then re-hit on stun frame 5
    ticks(1, 4'b0100);
    ticks(2, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    ticks(4, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0);
    ticks(14, 4'b1000);
    ticks(20, 4'b0000);
    // Kick+punch together, buttons held through recovery, then left+right together
    ticks(1, 4'b1100);
    ticks(12, 4'b0101);
    ticks(10, 4'b0000);
    ticks(3, 4'b0011);
    // Hit coincident with tick during active kick, reset mid-stun
    ticks(1, 4'b1000);
    ticks(4, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);
    ticks(3, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b1);
    rst_pulse();
    ticks(2, 4'b0000);

    cur_b = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(1'b0, 4'b0000, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cur_b = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0) cur_b[3:2] = 2'b00;
      end
      cyc(1'b1, cur_b, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) rst_pulse();
    end

    repeat (3) cyc(1'b0, 4'b0000, 1'b0);
    @(posedge vga_clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d predictions left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
Per-player animation sequencer for the fighter sprite pipeline. Samples player buttons once per video frame and steps a move state machine (idle, walk, punch, kick, hit-stun) with frame-counted phase durations. Drives the sprite-select and walk-cycle index consumed by the sprite ROM/palette renderers, plus hitbox/busy flags for collision logic. One instance per player, clocked by the pixel clock.

Parameters:
PUNCH_ACT, 6, frames punch sprite/hitbox is active
KICK_WIND, 4, kick wind-up frames (kick sprite shown, hitbox off)
KICK_ACT, 6, kick active frames (hitbox on)
RECOVER, 8, post-attack recovery frames (idle sprite, inputs ignored)
STUN, 12, hit-stun frames
WALK_DIV, 4, frames per walk-cycle step
WALK_FRAMES, 4, walk-cycle length (anim_frame wraps at WALK_FRAMES-1)

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge); only cycle where state may change
btn_punch  in  1  level, sampled at frame_tick
btn_kick  in  1  level, sampled at frame_tick
btn_left  in  1  level, sampled at frame_tick
btn_right  in  1  level, sampled at frame_tick
hit_taken  in  1  one-cycle pulse any time; latched until next frame_tick
sprite_sel  out  3  0 idle, 1 walk, 2 punch, 3 kick, 4 hurt
anim_frame  out  4  walk-cycle index; 0 outside WALK
hitbox_active  out  1  attack hitbox live
attack_type  out  2  0 none, 1 punch, 2 kick (valid when hitbox_active)
busy  out  1  high in any state other than IDLE/WALK

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, frame counter 0, walk divider 0, hit latch 0; sprite_sel=0, anim_frame=0, hitbox_active=0, attack_type=0, busy=0.
- All outputs registered, decoded from next state; they change on the same posedge that samples frame_tick=1 (visible the following cycle). No output changes on cycles without frame_tick.
- hit_latch: set by hit_taken on any cycle; cleared on frame_tick posedge (consumed). hit_taken coincident with frame_tick counts for that tick.
- States: IDLE, WALK, PUNCH, KICK_W, KICK_A, RECOV, HURT. Frame counter cnt loads (duration-1) on entry, decrements each frame_tick; phase ends on the tick where cnt==0.
- Priority at each frame_tick: (1) hit -> HURT, cnt=STUN-1, from any state including HURT (restarts stun) and mid-attack (attack aborted, hitbox off immediately). (2) In PUNCH/KICK_W/KICK_A/RECOV/HURT: no button effect; advance on cnt==0: PUNCH->RECOV, KICK_W->KICK_A, KICK_A->RECOV, RECOV->IDLE, HURT->IDLE. (3) In IDLE/WALK: kick -> KICK_W; else punch -> PUNCH; else exactly one of left/right -> WALK; else (none or both) -> IDLE.
- Outputs per state: IDLE/RECOV sprite 0; WALK sprite 1; PUNCH sprite 2, hitbox 1, type 1; KICK_W sprite 3, hitbox 0; KICK_A sprite 3, hitbox 1, type 2; HURT sprite 4. attack_type=0 whenever hitbox_active=0. busy=1 in PUNCH, KICK_W, KICK_A, RECOV, HURT.
- Walk cycle: on WALK entry anim_frame=0, divider=0. Each frame_tick staying in WALK: divider increments; at WALK_DIV-1 divider wraps to 0 and anim_frame increments, wrapping WALK_FRAMES-1 -> 0. Leaving WALK forces anim_frame=0.
- Durations of 1 are legal (phase lasts exactly one frame). Counter width = $clog2(max duration)+1.
- Reset mid-attack or mid-stun returns to IDLE on that edge; pending hit_latch discarded.

Test Plan:
- Reset, no buttons, 5 ticks -> sprite_sel=0, busy=0, hitbox_active=0 throughout.
- btn_kick held for 1 tick then released -> 4 ticks sprite 3/hitbox 0, 6 ticks sprite 3/hitbox 1/type 2, 8 ticks sprite 0/busy 1, then IDLE busy 0 (18 ticks total busy).
- btn_right held 20 ticks -> sprite 1; anim_frame 0,0,0,0,1,1,1,1,2...3,0 (wraps after 16 ticks); release -> anim_frame 0, sprite 0 next tick.
- PUNCH started, hit_taken pulse mid-frame on 3rd active frame -> next tick sprite 4, hitbox 0, busy 1 for 12 ticks; second hit on stun tick 5 -> stun restarts, 12 more ticks.
- btn_kick+btn_punch together at tick -> KICK_W; btn_left+btn_right together -> stays IDLE; buttons pressed during RECOV -> ignored.
- hit_taken coincident with frame_tick while in KICK_A -> HURT on that edge; reset_n=0 mid-HURT -> all outputs 0 next cycle.
